// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if: instruction-memory fetch bus between the fetch stage and imem
interface if_id_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;
  modport master(output req, addr, input ready, data);
  modport slave(input req, addr, output ready, data);
endinterface

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC, imem fetch request and IF/ID register with stall hold buffer and branch flush
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [31:0]                 branch_target_i,
  if_id_fetch_stage_if.master         imem,
  output logic [31:0]                 pc_o,
  output logic [31:0]                 if_id_pc_o,
  output logic [31:0]                 if_id_instr_o,
  output logic                        if_id_valid_o,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 flush_cnt_o
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [31:0] tgt;
  logic        active;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    tgt          = {branch_target_i[31:2], 2'b00};
    active       = state_q != IDLE;
    stall_cnt_d  = stall_cnt_q + {31'b0, active && stall_i};
    // a flush coinciding with a stall is dropped; the hazard unit re-issues it
    flush_cnt_d  = flush_cnt_q + {31'b0, active && flush_i && !stall_i};
    case (state_q)
      IDLE: state_d = start_i ? FETCH : IDLE;
      FETCH: begin
        if (stall_i) begin
          if (imem.ready) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem.data;
            state_d     = HOLD;
          end
        end else if (flush_i) begin
          pc_d         = tgt;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end else if (imem.ready) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem.data;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
        end else begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (!stall_i && flush_i) begin
          pc_d         = tgt;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          buf_pc_d     = '0;
          buf_instr_d  = '0;
          state_d      = FETCH;
        end else if (!stall_i) begin
          ifid_pc_d    = buf_pc_q;
          ifid_instr_d = buf_instr_q;
          ifid_valid_d = 1'b1;
          pc_d         = buf_pc_q + 32'd4;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign imem.req      = state_q == FETCH;
  assign imem.addr     = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;
  assign if_id_valid_o = ifid_valid_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

Front end of the 5-stage pipelined CPU: owns the PC, the instruction-memory fetch request and the IF/ID pipeline register. It is the consumer of the hazard unit's outputs. It holds the front end on a load-use stall, and on a taken branch it redirects the PC and injects a bubble into IF/ID. A one-entry hold buffer keeps an instruction that returns during a stall, so it is not lost or re-fetched.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  begin fetching; sampled only in IDLE
- stall_i  input  1  load-use stall request from hazard detection
- flush_i  input  1  branch-taken flush request from hazard detection
- branch_target_i  input  32  redirect address, valid when flush_i=1
- imem_ready_i  input  1  instruction memory returns imem_data_i this cycle
- imem_data_i  input  32  fetched instruction
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch address, equal to pc_o (combinational)
- pc_o  output  32  current fetch PC
- if_id_pc_o  output  32  PC of instruction in IF/ID
- if_id_instr_o  output  32  instruction in IF/ID; 0 (nop) when invalid
- if_id_valid_o  output  1  IF/ID holds a real instruction
- stall_cnt_o  output  32  cycles with stall_i=1 outside IDLE, wraps
- flush_cnt_o  output  32  accepted flushes, wraps

## Operation
- States: IDLE, FETCH, HOLD. The hold buffer holds {pc, instr}.
- Event priority, highest first: rst_i, stall_i, flush_i, normal advance.
  - When stall_i and flush_i are both high, stall wins and the flush is ignored that cycle. The branch operands are not yet valid; the hazard unit re-asserts flush later.
  - flush_cnt_o does not count an ignored flush.
- **IDLE**
  - imem_req_o=0; all outputs hold their reset values.
  - start_i=1 moves to FETCH next cycle.
- **FETCH**
  - imem_req_o=1.
  - imem_ready_i=1 with stall_i=1:
    - buffer takes {pc_o, imem_data_i};
    - pc_o, IF/ID and the hold buffer are unchanged except for this capture;
    - go to HOLD.
  - imem_ready_i=1 with flush_i=1:
    - pc_o takes {branch_target_i[31:2], 2'b00};
    - IF/ID becomes a bubble (valid=0, instr=0, pc=0);
    - the fetched word is discarded; stay in FETCH.
  - imem_ready_i=1, no stall or flush:
    - IF/ID takes {pc_o, imem_data_i, valid=1};
    - pc_o takes pc_o+4.
  - imem_ready_i=0 with stall_i=1: everything holds.
  - imem_ready_i=0 with flush_i=1: redirect the PC and bubble IF/ID as above. The request continues at the new address.
  - imem_ready_i=0, no stall or flush: IF/ID becomes a bubble; pc_o is unchanged.
- **HOLD**
  - imem_req_o=0.
  - stall_i=1: stay in HOLD.
  - flush_i=1:
    - discard the buffer;
    - redirect the PC;
    - bubble IF/ID;
    - go to FETCH.
  - No stall or flush:
    - IF/ID takes the buffer with valid=1;
    - pc_o takes buffer pc+4;
    - go to FETCH.
- start_i is ignored outside IDLE. Only rst_i returns the block to IDLE.
- Arithmetic rules:
  - pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC becomes 0.
  - branch_target_i[1:0] is forced to 0.
  - Both counters wrap modulo 2^32.

## Timing
- Reset values:
  - state IDLE;
  - pc_o=RESET_PC, imem_req_o=0;
  - if_id_pc_o=0, if_id_instr_o=0, if_id_valid_o=0;
  - hold buffer cleared;
  - stall_cnt_o=0, flush_cnt_o=0.
- Latency from start_i to the first request: start_i sampled high at edge N gives imem_req_o=1 during cycle N+1.
- With imem_ready_i=1 every cycle, the block fetches one instruction per cycle. The instruction fetched in cycle k appears in IF/ID after edge k+1.
- stall_i and flush_i act on the same edge they are sampled. Redirect and bubble are visible in the cycle after the edge.
- A stall lasting S cycles inserts S cycles of IF/ID hold. The held instruction is neither lost nor duplicated.
- Reset mid-operation: rst_i high at any edge forces all reset values. The hold buffer contents and any in-flight fetch are dropped.

## Test plan
- **Reset and start:** hold rst_i 2 cycles, then start_i=1 with RESET_PC=0 and imem_ready_i=1 returning addr+100 -> IF/ID shows (0,100), (4,104), (8,108) on consecutive cycles.
- **Load-use stall:** stall_i=1 for 2 cycles during the cycle that fetches pc=8 -> IF/ID holds (4,104) for 2 cycles, then (8,108), then (C,10C); stall_cnt_o=2; no address re-fetched.
- **Branch flush:** flush_i=1 with branch_target_i=32'h40 while fetching pc=C -> next cycle if_id_valid_o=0, if_id_instr_o=0, pc_o=40; following cycle IF/ID=(40,140); flush_cnt_o=1.
- **Stall and flush together:** stall_i=1, flush_i=1, branch_target_i=32'h80 -> pc_o unchanged, IF/ID held, flush_cnt_o unchanged. Then flush_i alone -> pc_o=80.
- **Flush in HOLD:** stall_i=1 for one cycle, then flush_i=1 with target 32'h23 -> buffer discarded, pc_o=20, IF/ID bubble, next IF/ID=(20,120).
- **Slow memory, wrap, mid-run reset:**
  - imem_ready_i=0 for 3 cycles with no stall -> three bubbles, pc_o constant.
  - RESET_PC=32'hFFFF_FFFC -> after one fetch pc_o=0.
  - rst_i pulsed during HOLD -> all outputs back to reset values, state IDLE.
